// File: rtl/dpo_fsm.sv
// rtl/dpo_fsm.sv - Data-port-output FSM: drains the DPO FIFO into the FX3 GPIF-II slave FIFO.
module dpo_fsm #(
  parameter int MAX_WRD_PER_TRANS = 8,
  parameter int FLAG_LAT          = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        strt_i,
  output logic        done_o,
  input  logic        FLAG_i,
  output logic        SLWRn_o,
  output logic        PKTENDn_o,
  input  logic        pkt_end_en_i,
  input  logic [31:0] dpo_dt_i,
  input  logic        dpo_empty_i,
  output logic        dpo_rd_o,
  output logic [31:0] dpo_dt_o,
  output logic        dpo_dt_oe_o
);

  localparam logic [7:0] MAX_W    = 8'(MAX_WRD_PER_TRANS);
  localparam logic [3:0] LAT_LAST = 4'(FLAG_LAT - 1);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    FIFO_RD_REQ = 4'd1,
    FIFO_DT_WT  = 4'd2,
    LTCH_DT     = 4'd3,
    FX3_WR      = 4'd4,
    FX3_WT_FLG  = 4'd5,
    CHK_FLG     = 4'd6,
    PKT_END     = 4'd7,
    DONE        = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wrd_cnt_q;
  logic [3:0]  wt_cnt_q;
  logic [31:0] dt_q;
  logic        ltch_en, cnt_clr, cnt_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wrd_cnt_q <= 8'd0;
      wt_cnt_q  <= 4'd0;
      dt_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      if (cnt_clr)
        wrd_cnt_q <= 8'd0;
      else if (cnt_inc && wrd_cnt_q != 8'hFF)
        wrd_cnt_q <= wrd_cnt_q + 8'd1;
      // Flag-latency counter only runs while waiting, so it restarts at 0 for every word.
      if (state_q == FX3_WT_FLG)
        wt_cnt_q <= wt_cnt_q + 4'd1;
      else
        wt_cnt_q <= 4'd0;
      if (ltch_en)
        dt_q <= dpo_dt_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    SLWRn_o     = 1'b1;
    PKTENDn_o   = 1'b1;
    dpo_rd_o    = 1'b0;
    dpo_dt_oe_o = 1'b0;
    done_o      = 1'b0;
    ltch_en     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (strt_i && !FLAG_i && !dpo_empty_i)
          state_d = FIFO_RD_REQ;
        else if (strt_i)
          state_d = DONE;
      end
      FIFO_RD_REQ: begin
        dpo_rd_o = 1'b1;
        state_d  = FIFO_DT_WT;
      end
      FIFO_DT_WT: state_d = LTCH_DT;
      LTCH_DT: begin
        ltch_en     = 1'b1;
        dpo_dt_oe_o = 1'b1;
        state_d     = FX3_WR;
      end
      FX3_WR: begin
        SLWRn_o     = 1'b0;
        dpo_dt_oe_o = 1'b1;
        cnt_inc     = 1'b1;
        state_d     = FX3_WT_FLG;
      end
      FX3_WT_FLG: begin
        dpo_dt_oe_o = 1'b1;
        if (wt_cnt_q == LAT_LAST)
          state_d = CHK_FLG;
      end
      CHK_FLG: begin
        if (wrd_cnt_q >= MAX_W)
          state_d = DONE;
        else if (FLAG_i)
          state_d = DONE;
        else if (dpo_empty_i)
          state_d = pkt_end_en_i ? PKT_END : DONE;
        else
          state_d = FIFO_RD_REQ;
      end
      PKT_END: begin
        PKTENDn_o = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dpo_dt_o = dt_q;

endmodule

// File: tb/tb_dpo_fsm.sv
// tb/tb_dpo_fsm.sv - Self-checking bench for dpo_fsm with a FIFO model and write-data scoreboard.
module tb_dpo_fsm;

  logic        clk_i = 1'b0;
  logic        rst_i, strt_i, done_o, FLAG_i, SLWRn_o, PKTENDn_o, pkt_end_en_i;
  logic [31:0] dpo_dt_i, dpo_dt_o;
  logic        dpo_empty_i, dpo_rd_o, dpo_dt_oe_o;

  dpo_fsm #(.MAX_WRD_PER_TRANS(8), .FLAG_LAT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .strt_i(strt_i), .done_o(done_o), .FLAG_i(FLAG_i),
    .SLWRn_o(SLWRn_o), .PKTENDn_o(PKTENDn_o), .pkt_end_en_i(pkt_end_en_i),
    .dpo_dt_i(dpo_dt_i), .dpo_empty_i(dpo_empty_i), .dpo_rd_o(dpo_rd_o),
    .dpo_dt_o(dpo_dt_o), .dpo_dt_oe_o(dpo_dt_oe_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int load; bit rnd; bit pe_en; bit flag0; int flag_after;
    int exp_wr; int exp_pe; int exp_lat; int exp_rem;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] mem[64];
  logic [31:0] exp_q[$];
  int head = 0, tail = 0;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_wr = 0, n_rd = 0, n_pe = 0, n_done = 0, n_oe = 0, n_oe_bad = 0;
  int done_cyc = 0, base_wr = 0, flag_after = 0;
  bit rd_q = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: FIFO model responds to last cycle's read, then outputs are monitored.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (rd_q && head != tail) begin
      dpo_dt_i = mem[head];
      head++;
    end
    dpo_empty_i = (head == tail);
    rd_q = dpo_rd_o;
    if (dpo_rd_o) n_rd++;
    if (dpo_dt_oe_o) n_oe++;
    if (dpo_dt_oe_o && (done_o || !PKTENDn_o || dpo_rd_o)) n_oe_bad++;
    if (!PKTENDn_o) n_pe++;
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (!SLWRn_o) begin
      n_wr++;
      if (exp_q.size() == 0)
        check("unexpected_write", 64'(dpo_dt_o), 64'hDEAD);
      else
        check("write_data", 64'(dpo_dt_o), 64'(exp_q.pop_front()));
      if (flag_after != 0 && n_wr - base_wr == flag_after) FLAG_i = 1'b1;
    end
  endtask

  task automatic load(input int n, input bit rnd, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      mem[tail] = rnd ? $urandom : base + 32'(i);
      tail++;
    end
    dpo_empty_i = (head == tail);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int b_rd, b_pe, b_done, b_oe, b_bad, c0, budget;
    for (int i = 0; i < v.exp_wr; i++) exp_q.push_back(mem[head + i]);
    base_wr = n_wr; b_rd = n_rd; b_pe = n_pe; b_done = n_done; b_oe = n_oe; b_bad = n_oe_bad;
    flag_after = v.flag_after;
    pkt_end_en_i = v.pe_en;
    FLAG_i = v.flag0;
    strt_i = 1'b1;
    tick();
    strt_i = 1'b0;
    c0 = cyc;
    budget = 300;
    while (n_done == b_done && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check({nm, "_done_timeout"}, 0, 1);
    tick();
    tick();
    check({nm, "_writes"}, 64'(n_wr - base_wr), 64'(v.exp_wr));
    check({nm, "_reads"}, 64'(n_rd - b_rd), 64'(v.exp_wr));
    check({nm, "_pktend"}, 64'(n_pe - b_pe), 64'(v.exp_pe));
    check({nm, "_done_cnt"}, 64'(n_done - b_done), 64'd1);
    check({nm, "_latency"}, 64'(done_cyc - c0 + 1), 64'(v.exp_lat));
    check({nm, "_oe_cycles"}, 64'(n_oe - b_oe), 64'(5 * v.exp_wr));
    check({nm, "_oe_overlap"}, 64'(n_oe_bad - b_bad), 64'd0);
    check({nm, "_fifo_left"}, 64'(tail - head), 64'(v.exp_rem));
    check({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    FLAG_i = 1'b0;
    flag_after = 0;
  endtask

  initial begin
    int b_done, b_pe;
    vecs[0] = '{3,  1'b0, 1'b1, 1'b0, 0, 3, 1, 26, 0};
    vecs[1] = '{20, 1'b1, 1'b1, 1'b0, 0, 8, 0, 65, 12};
    vecs[2] = '{0,  1'b1, 1'b1, 1'b0, 0, 8, 0, 65, 4};
    vecs[3] = '{0,  1'b1, 1'b1, 1'b0, 0, 4, 1, 34, 0};
    vecs[4] = '{0,  1'b1, 1'b1, 1'b0, 0, 0, 0, 1,  0};
    vecs[5] = '{2,  1'b1, 1'b1, 1'b1, 0, 0, 0, 1,  2};
    vecs[6] = '{8,  1'b1, 1'b1, 1'b0, 2, 2, 0, 17, 8};
    vecs[7] = '{0,  1'b1, 1'b0, 1'b0, 0, 8, 0, 65, 0};
    vecs[8] = '{1,  1'b1, 1'b0, 1'b0, 0, 1, 0, 9,  0};

    rst_i = 1'b1; strt_i = 1'b0; FLAG_i = 1'b0; pkt_end_en_i = 1'b1;
    dpo_dt_i = 32'h0; dpo_empty_i = 1'b1;
    tick();
    tick();
    check("rst_slwrn", 64'(SLWRn_o), 64'd1);
    check("rst_pktendn", 64'(PKTENDn_o), 64'd1);
    check("rst_rd", 64'(dpo_rd_o), 64'd0);
    check("rst_oe", 64'(dpo_dt_oe_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_data", 64'(dpo_dt_o), 64'd0);
    rst_i = 1'b0;
    tick();

    for (int k = 0; k < 9; k++) begin
      load(vecs[k].load, vecs[k].rnd, 32'hA0);
      run_txn(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset during FX3_WR of word 4: word 4 is abandoned, no done or PKTEND.
    load(6, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[head + i]);
    base_wr = n_wr; b_done = n_done; b_pe = n_pe;
    pkt_end_en_i = 1'b1;
    strt_i = 1'b1;
    tick();
    strt_i = 1'b0;
    for (int i = 0; i < 200 && (n_wr - base_wr) < 4; i++) tick();
    check("rstmid_reached_wr4", 64'(n_wr - base_wr), 64'd4);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rstmid_slwrn", 64'(SLWRn_o), 64'd1);
    check("rstmid_pktendn", 64'(PKTENDn_o), 64'd1);
    check("rstmid_rd", 64'(dpo_rd_o), 64'd0);
    check("rstmid_oe", 64'(dpo_dt_oe_o), 64'd0);
    check("rstmid_data", 64'(dpo_dt_o), 64'd0);
    tick();
    tick();
    check("rstmid_no_done", 64'(n_done - b_done), 64'd0);
    check("rstmid_no_pktend", 64'(n_pe - b_pe), 64'd0);
    check("rstmid_fifo_left", 64'(tail - head), 64'd2);
    run_txn('{0, 1'b1, 1'b1, 1'b0, 0, 2, 1, 18, 0}, "resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpo_fsm.md
# dpo_fsm

Data-port-output FSM of the FX3 controller: the downstream-to-host counterpart of the input data port FSM. On each start pulse it drains up to `MAX_WRD_PER_TRANS` 32-bit words from the data-port-out FIFO and writes them to the FX3 GPIF-II slave FIFO. It honours the FX3 full flag and optionally commits a short packet with PKTEND when the FIFO runs dry. It sits between the DPO FIFO read port and the GPIF-II bus drivers, under the same top-level arbiter that issues `strt_i` and waits for `done_o`.

## Interface
- `MAX_WRD_PER_TRANS`, 8, maximum words written per start (1..255).
- `FLAG_LAT`, 3, wait cycles after each write before `FLAG_i` is trusted (1..15).
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `strt_i` in 1: start one transaction; sampled only in IDLE.
- `done_o` out 1: one-cycle pulse when the transaction ends.
- `FLAG_i` in 1: 1 = FX3 write buffer cannot accept data.
- `SLWRn_o` out 1: slave FIFO write strobe, active low.
- `PKTENDn_o` out 1: packet-end strobe, active low.
- `pkt_end_en_i` in 1: enables the PKTEND commit on FIFO-empty termination.
- `dpo_dt_i` in 32: DPO FIFO read data; valid one cycle after `dpo_rd_o`.
- `dpo_empty_i` in 1: DPO FIFO empty flag.
- `dpo_rd_o` out 1: DPO FIFO read enable.
- `dpo_dt_o` out 32: latched data driven to the GPIF-II bus.
- `dpo_dt_oe_o` out 1: GPIF-II data bus output enable.

## Operation
- States: IDLE, FIFO_RD_REQ, FIFO_DT_WT, LTCH_DT, FX3_WR, FX3_WT_FLG, CHK_FLG, PKT_END, DONE.
- Control outputs (`SLWRn_o`, `PKTENDn_o`, `dpo_rd_o`, `dpo_dt_oe_o`, `done_o`, latch enable, counter clear and increment) are decoded from the current state only (Moore).
- IDLE:
  - Word counter cleared.
  - If `strt_i & !FLAG_i & !dpo_empty_i`, go to FIFO_RD_REQ.
  - Else if `strt_i`, go to DONE (empty transaction, no bus activity).
  - Else stay in IDLE.
- FIFO_RD_REQ: `dpo_rd_o`=1 → FIFO_DT_WT.
- FIFO_DT_WT: no outputs active → LTCH_DT.
- LTCH_DT: 32-bit data register loads `dpo_dt_i` at the end of the cycle; `dpo_dt_oe_o`=1 → FX3_WR.
- FX3_WR: `SLWRn_o`=0, `dpo_dt_oe_o`=1, word counter +1 → FX3_WT_FLG.
- FX3_WT_FLG: `dpo_dt_oe_o`=1 (data held); wait counter runs `FLAG_LAT` cycles → CHK_FLG.
- CHK_FLG, evaluated in priority order:
  1. counter ≥ `MAX_WRD_PER_TRANS` → DONE.
  2. `FLAG_i`=1 → DONE.
  3. `dpo_empty_i`=1 → PKT_END if `pkt_end_en_i`, else DONE.
  4. Otherwise → FIFO_RD_REQ.
- PKT_END: `PKTENDn_o`=0 for one cycle → DONE.
- DONE: `done_o`=1 → IDLE.
- Unreachable state codes → IDLE, all outputs inactive.
- Word counter: 8-bit, saturating at 255, cleared only in IDLE and on reset.
- Data register: holds its value between latches and is never cleared except by reset.

## Timing
- Reset values: `SLWRn_o`=1, `PKTENDn_o`=1, `dpo_rd_o`=0, `dpo_dt_oe_o`=0, `done_o`=0, `dpo_dt_o`=0; state IDLE; counters 0.
- Reset asserted mid-transaction:
  - Next cycle is IDLE with all strobes inactive.
  - A partially written word is abandoned.
  - No `done_o` and no PKTEND are issued.
- `strt_i` sampled in IDLE only; pulses received in other states are ignored.
- Per word: 4 + `FLAG_LAT` cycles (RD_REQ, DT_WT, LTCH, WR, then the FLAG_LAT wait cycles) plus 1 cycle CHK_FLG.
- N-word burst with defaults: `done_o` asserts 8N+1 cycles after the `strt_i` sample, or 8N+2 with PKTEND.
- Exactly one `dpo_rd_o` pulse per `SLWRn_o` pulse; `dpo_dt_o` is stable for the whole cycle `SLWRn_o`=0.
- `dpo_dt_oe_o` high from LTCH_DT through FX3_WT_FLG of each word; low in IDLE, CHK_FLG, PKT_END and DONE.
- `FLAG_i` and `dpo_empty_i` are ignored outside IDLE and CHK_FLG.

## Test plan
- FIFO holds 3 words (0xA0..0xA2), `FLAG_i`=0, `pkt_end_en_i`=1, `strt_i` pulse → 3 SLWRn pulses carrying 0xA0, 0xA1, 0xA2 in order, one PKTENDn pulse, then `done_o` 1 cycle later, 26 cycles after the start sample.
- FIFO holds 20 words, defaults → exactly 8 writes, no PKTEND, `done_o`; a second `strt_i` writes words 9..16.
- `FLAG_i` rises during the FX3_WT_FLG wait of word 2 with 10 words queued → 2 writes, `done_o`, no PKTEND, FIFO left with 8 words.
- `strt_i` with `dpo_empty_i`=1, or with `FLAG_i`=1 → `done_o` the next cycle; no `dpo_rd_o`, SLWRn or oe activity.
- `pkt_end_en_i`=0 with 1 word queued → 1 write, `done_o`, `PKTENDn_o` held at 1.
- `rst_i` pulsed during FX3_WR of word 4 → next cycle all outputs at reset values and `done_o`=0; a fresh `strt_i` resumes correctly from the next FIFO word.
